// File: rtl/io_evt_pkg.sv
// Shared constants and types for the IO event queue.
package io_evt_pkg;

  // Event IDs delivered to the consumer are always one byte wide.
  localparam int unsigned EVT_ID_W = 8;

  typedef logic [EVT_ID_W-1:0] evt_id_t;

  // Default source count and per-source counter width.
  localparam int unsigned N_EVT_DEFAULT = 32;
  localparam int unsigned CNT_W_DEFAULT = 2;

  // Width of a source index; at least one bit so a single-source build still has a pointer.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_evt_rr_arb.sv
// Combinational round-robin picker: first requesting source at or above ptr, wrapping to 0.
module io_evt_rr_arb
  import io_evt_pkg::*;
#(
  parameter int unsigned N_EVT = N_EVT_DEFAULT,
  localparam int unsigned IDX_W = idx_width(N_EVT)
) (
  input  logic [N_EVT-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  // Scan N_EVT positions starting at ptr; the first hit wins.
  always_comb begin
    logic [IDX_W:0] pos;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pos       = '0;
    for (int i = 0; i < int'(N_EVT); i++) begin
      // ptr is always below N_EVT, so one conditional subtraction wraps the index.
      pos = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (pos >= (IDX_W + 1)'(N_EVT)) begin
        pos = pos - (IDX_W + 1)'(N_EVT);
      end
      if (!gnt_valid && req[pos[IDX_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/io_event_queue.sv
// Event queue: per-source saturating pending counters, round-robin selection and a single
// valid/ready output register that presents one event ID at a time.
module io_event_queue
  import io_evt_pkg::*;
#(
  parameter int unsigned N_EVT     = N_EVT_DEFAULT,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT,
  parameter int unsigned ID_OFFSET = 0
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic [N_EVT-1:0] evt_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic             event_valid_o,
  output evt_id_t          event_data_o,
  input  logic             event_ready_i,
  output logic [N_EVT-1:0] pending_o,
  output logic             drop_o
);

  localparam int unsigned IDX_W = idx_width(N_EVT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_EVT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]            ptr_q, ptr_d;
  logic                        valid_q;
  evt_id_t                     data_q;
  logic                        drop_q, drop_d;

  logic [N_EVT-1:0] req;
  logic [N_EVT-1:0] gnt_onehot;
  logic [N_EVT-1:0] lost;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             out_free;
  logic             grant;
  evt_id_t          gnt_id;

  // A source requests service whenever it has at least one pending event.
  always_comb begin
    for (int k = 0; k < int'(N_EVT); k++) begin
      req[k] = (cnt_q[k] != '0);
    end
  end

  io_evt_rr_arb #(
    .N_EVT (N_EVT)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Grant decision: output slot free (empty or handing off this cycle), enabled, not flushing.
  always_comb begin
    out_free = !valid_q || event_ready_i;
    grant    = out_free && en_i && !clr_i && gnt_valid;
    gnt_id   = evt_id_t'(ID_OFFSET + 32'(gnt_idx));
    for (int k = 0; k < int'(N_EVT); k++) begin
      gnt_onehot[k] = grant && (gnt_idx == IDX_W'(k));
    end
  end

  // Counter next state: a pulse and a grant on the same source cancel out; a pulse into a full
  // counter that is not being drained is lost and reported.
  always_comb begin
    cnt_d = cnt_q;
    lost  = '0;
    for (int k = 0; k < int'(N_EVT); k++) begin
      if (clr_i) begin
        cnt_d[k] = '0;
      end else if (evt_i[k] && !gnt_onehot[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          lost[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end else if (!evt_i[k] && gnt_onehot[k]) begin
        cnt_d[k] = cnt_q[k] - CNT_W'(1);
      end
    end
    drop_d = |lost;
  end

  // Pointer moves just past the granted source; a flush returns it to source 0.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (grant) begin
      ptr_d = (gnt_idx == IDX_W'(N_EVT - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  // Counter, pointer and drop state.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      cnt_q  <= '0;
      ptr_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      drop_q <= drop_d;
    end
  end

  // Output register: reloads only when free; a held event ignores en_i and clr_i.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (out_free) begin
      valid_q <= grant;
      if (grant) begin
        data_q <= gnt_id;
      end
    end
  end

  assign event_valid_o = valid_q;
  assign event_data_o  = data_q;
  assign pending_o     = req;
  assign drop_o        = drop_q;

endmodule

// File: tb/tb_io_event_queue.sv
// Self-checking bench for io_event_queue: directed scenarios plus random traffic, checked against
// a counting model and a scoreboard of expected event IDs.
module tb_io_event_queue;

  localparam int N    = 8;
  localparam int CW   = 2;
  localparam int OFF  = 0;
  localparam int CMAX = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] evt;
  logic         en, clr, rdy;
  logic         vld;
  logic [7:0]   data;
  logic [N-1:0] pend;
  logic         drop;

  int checks = 0;
  int errors = 0;

  // Reference state: pending count per source, next-search position, presented event.
  int m_cnt[N];
  int m_ptr;
  bit m_valid;
  int m_data;
  bit m_drop;
  int exp_q[$];

  always #5 clk = ~clk;

  io_event_queue #(
    .N_EVT     (N),
    .CNT_W     (CW),
    .ID_OFFSET (OFF)
  ) dut (
    .sys_clk_i     (clk),
    .sys_rst_i     (rst),
    .evt_i         (evt),
    .en_i          (en),
    .clr_i         (clr),
    .event_valid_o (vld),
    .event_data_o  (data),
    .event_ready_i (rdy),
    .pending_o     (pend),
    .drop_o        (drop)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] m_pending();
    logic [N-1:0] p;
    for (int k = 0; k < N; k++) p[k] = (m_cnt[k] != 0);
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    m_ptr   = 0;
    m_valid = 0;
    m_data  = 0;
    m_drop  = 0;
    exp_q.delete();
  endtask

  // One clock of behaviour: pick the next source by rotating search, then net the arithmetic.
  task automatic model_step(input logic [N-1:0] e, input bit en_v, input bit rdy_v,
                            input bit clr_v);
    bit free;
    int g;
    bit d;
    int c;
    free = !m_valid || rdy_v;
    g = -1;
    if (free && en_v && !clr_v) begin
      for (int i = 0; i < N; i++) begin
        if (m_cnt[(m_ptr + i) % N] > 0) begin
          g = (m_ptr + i) % N;
          break;
        end
      end
    end
    d = 0;
    for (int k = 0; k < N; k++) begin
      if (clr_v) begin
        m_cnt[k] = 0;
      end else begin
        c = m_cnt[k] + int'(e[k]) - ((k == g) ? 1 : 0);
        if (c > CMAX) begin
          c = CMAX;
          d = 1;
        end
        m_cnt[k] = c;
      end
    end
    m_drop = d;
    if (clr_v) m_ptr = 0;
    else if (g >= 0) m_ptr = (g + 1) % N;
    if (free) begin
      if (g >= 0) begin
        m_valid = 1;
        m_data  = (OFF + g) % 256;
        exp_q.push_back(m_data);
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic compare();
    check("valid", vld, m_valid);
    check("drop", drop, m_drop);
    check("pending", pend, m_pending());
    if (m_valid) check("data", data, m_data);
  endtask

  // Leaves inputs applied for the new cycle; DUT outputs then show this cycle's state.
  task automatic step(input logic [N-1:0] e, input bit en_v, input bit rdy_v, input bit clr_v);
    @(posedge clk);
    #1;
    compare();
    evt = e;
    en  = en_v;
    rdy = rdy_v;
    clr = clr_v;
    model_step(e, en_v, rdy_v, clr_v);
  endtask

  task automatic rand_step();
    logic [N-1:0] e;
    e = N'($urandom & $urandom);
    step(e, $urandom_range(7) != 0, $urandom_range(3) != 0, $urandom_range(31) == 0);
  endtask

  // Scoreboard monitor: every accepted event must match the oldest predicted grant.
  always @(negedge clk) begin
    if (rst === 1'b0 && vld === 1'b1 && rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got event %0d expected none", data);
      end else begin
        check("scoreboard", data, exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    int nd;
    rst = 1'b1;
    evt = '0;
    en  = 1'b0;
    clr = 1'b0;
    rdy = 1'b0;
    model_reset();
    #1;
    check("reset_valid", vld, 0);
    check("reset_data", data, 0);
    check("reset_pending", pend, 0);
    check("reset_drop", drop, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single event on source 5.
    step('0, 1, 1, 1);
    step(8'h20, 1, 1, 0);
    step('0, 1, 1, 0);
    check("single_t1_valid", vld, 0);
    step('0, 1, 1, 0);
    check("single_t2_valid", vld, 1);
    check("single_t2_data", data, 5);
    step('0, 1, 1, 0);
    check("single_t3_valid", vld, 0);
    check("single_t3_pending", pend, 0);

    // Sources 1, 3, 7 together from pointer 0.
    step('0, 1, 1, 1);
    step(8'h8A, 1, 1, 0);
    step('0, 1, 1, 0);
    step('0, 1, 1, 0);
    check("simul_first", data, 1);
    step('0, 1, 1, 0);
    check("simul_second", data, 3);
    step('0, 1, 1, 0);
    check("simul_third", data, 7);
    check("simul_third_valid", vld, 1);
    step('0, 1, 1, 0);
    check("simul_done", vld, 0);

    // Backpressure with sources 1 and 4 pending.
    step('0, 1, 1, 1);
    step(8'h12, 1, 0, 0);
    step('0, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step('0, 1, 0, 0);
      if (vld === 1'b1 && data === 8'd1) n++;
    end
    check("bp_stable_cycles", n, 10);
    step('0, 1, 1, 0);
    check("bp_accept_data", data, 1);
    step('0, 1, 1, 0);
    check("bp_next_data", data, 4);
    check("bp_next_valid", vld, 1);

    // Saturation: four pulses on source 0 while disabled.
    step('0, 1, 1, 1);
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      step(8'h01, 0, 1, 0);
      nd += int'(drop);
    end
    for (int i = 0; i < 3; i++) begin
      step('0, 0, 1, 0);
      nd += int'(drop);
    end
    check("sat_drops", nd, 1);
    check("sat_pending", pend, 8'h01);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step('0, 1, 1, 0);
      if (vld === 1'b1 && data === 8'd0) n++;
    end
    check("sat_events", n, 3);

    // Pulse on source 2 in the cycle it is granted with a full counter.
    step('0, 1, 1, 1);
    for (int i = 0; i < 3; i++) step(8'h04, 0, 1, 0);
    step(8'h04, 1, 1, 0);
    step('0, 1, 1, 0);
    check("coll_drop", drop, 0);
    check("coll_data", data, 2);
    n  = int'(vld);
    nd = 0;
    for (int i = 0; i < 7; i++) begin
      step('0, 1, 1, 0);
      n  += int'(vld);
      nd += int'(drop);
    end
    check("coll_events", n, 4);
    check("coll_no_drop", nd, 0);

    // Flush while an event is held.
    step('0, 1, 1, 1);
    step(8'h0F, 0, 0, 0);
    step('0, 1, 0, 0);
    check("clr_pending_before", pend, 8'h0F);
    step('0, 1, 0, 1);
    step('0, 1, 0, 0);
    check("clr_held_valid", vld, 1);
    check("clr_held_data", data, 0);
    check("clr_pending_after", pend, 0);
    step('0, 1, 1, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step('0, 1, 1, 0);
      n += int'(vld);
    end
    check("clr_no_more", n, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) rand_step();

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 20; i++) step(N'($urandom | $urandom), 1, $urandom_range(1) == 1, 0);
    #2 rst = 1'b1;
    evt = '0;
    #1;
    check("midrst_valid", vld, 0);
    check("midrst_data", data, 0);
    check("midrst_pending", pend, 0);
    check("midrst_drop", drop, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 200; i++) rand_step();

    // Drain everything and confirm every predicted event was delivered.
    for (int i = 0; i < 40; i++) step('0, 1, 1, 0);
    @(posedge clk);
    #1;
    compare();
    @(negedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
